decode_stage: RTL
=================

// Module: decode_stage
// PURPOSE
//  Registered RV32I decode stage between fetch and execute of the pipelined core.
//  Accepts one 32-bit instruction per cycle over valid/ready and emits a fully decoded
//  DecodedOp: fields, sign-extended immediate, control flags and illegal flag.
//  Output is held in a FIFO_DEPTH-entry buffer so execute stalls never drop work.
//  Successor to the single-cycle combinational decode: parametrised data width and
//  buffer depth, flush support, illegal-instruction detection.
// PARAMETERS
//  DATA_WIDTH   32  immediate/data width; immediates sign-extend to this width (>=32)
//  ADDR_WIDTH   32  PC width carried alongside each op
//  FIFO_DEPTH   2   output buffer entries; power of two, >=2
// PORTS
//  clk         in   1           clock, rising edge
//  rst_n       in   1           synchronous, active-low reset
//  flush       in   1           discard buffered and incoming ops this cycle
//  in_valid    in   1           fetch presents insn/in_pc
//  in_ready    out  1           stage can accept; = !full
//  insn        in   32          raw instruction word
//  in_pc       in   ADDR_WIDTH  PC of insn
//  out_valid   out  1           head entry valid; = !empty
//  out_ready   in   1           execute consumes head
//  out_op      out  DecodedOp   decoded head entry
//  out_pc      out  ADDR_WIDTH  PC of head entry
//  occupancy   out  $clog2(FIFO_DEPTH)+1  entries held
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): empty; out_valid=0, in_ready=1, occupancy=0, out_op/out_pc=0.
//    Reset mid-operation discards all entries; no partial state survives.
//  - Enqueue when in_valid&&in_ready; dequeue when out_valid&&out_ready. Latency 1 cycle:
//    insn accepted at edge N is visible on out_op after edge N when the buffer was empty.
//  - Simultaneous enq+deq when full: in_ready=0 (no combinational ready path), enq blocked.
//    Simultaneous enq+deq otherwise: occupancy unchanged, order preserved.
//  - flush: after edge buffer empty; same-cycle enqueue dropped; flush wins over enq/deq.
//  - Pointers wrap modulo FIFO_DEPTH; occupancy saturates at FIFO_DEPTH, never exceeds.
//  - Decode is combinational on insn, registered on enqueue:
//    opcode/rd/rs1/rs2/funct3/funct7; shamt=insn[24:20];
//    imm per format I/S/B/U/J, sign-extended from insn[31] to DATA_WIDTH; B/J lsb=0.
//    aluCode=funct3 for OP/OP_IMM, ADD for LOAD/STORE/AUIPC/JAL/JALR/LUI.
//    brCode=funct3 for BRANCH. isBranch/isJump/isLoad/isStore per opcode.
//    isALUInConstant=1 for OP_IMM/LOAD/STORE/LUI/AUIPC.
//    regWrEnable=1 for OP/OP_IMM/LOAD/LUI/AUIPC/JAL/JALR, forced 0 when rd==0.
//  - isIllegal=1 for: unknown opcode, insn[1:0]!=2'b11, reserved funct3 (BRANCH 010/011,
//    LOAD 011/110/111, STORE >=011), OP funct7 not in {0000000,0100000 (funct3 000/101)}.
//    Illegal ops still enqueue; all enables (reg/load/store/branch/jump) forced 0.
// CONFIGURATION
//  DECODE_MUL_DIV_EN defined: OP with funct7=0000001 decodes as RV32M, isMulDiv=1,
//    aluCode=funct3, regWrEnable per rd rule, isIllegal=0.
//  Undefined: funct7=0000001 is illegal; isMulDiv field tied 0.
// STRUCTURE
//  - Shared package DecodeTypes (imports BasicTypes, Types): DecodedOp struct
//    (OpInfo fields + imm[DATA_WIDTH] + isIllegal + isMulDiv), ImmFormat enum
//    (IMM_I/S/B/U/J/NONE), funct7 constant FUNCT7_MULDIV=7'b0000001.
//  - Sub-module imm_gen: combinational, (insn, ImmFormat) -> DATA_WIDTH immediate.
//  - Buffer: register array + rd/wr pointers + count, in this module.
// TESTING
//  1. 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle OP_IMM, rd=1, imm=5,
//     regWrEnable=1, isALUInConstant=1.
//  2. 0xFE208CE3 (beq x1,x2,-8) -> isBranch=1, brCode=EQ, rs1=1, rs2=2,
//     imm=all-ones...FFF8, regWrEnable=0.
//  3. 0x00000000 and 0x0000707F -> isIllegal=1, all enables 0, still dequeued in order.
//  4. out_ready=0, stream 3 insns -> first 2 accepted, in_ready=0, occupancy=2; release
//     -> outputs in order, no loss or duplication.
//  5. Buffer holds 2, flush with in_valid=1 -> next cycle out_valid=0, occupancy=0;
//     flushed insn never appears.
//  6. 0x022081B3 (mul x3,x1,x2): with DECODE_MUL_DIV_EN isMulDiv=1, rd=3, isIllegal=0;
//     without, isIllegal=1. Assert rst_n=0 with 2 entries -> empty next cycle.

Source files
------------

// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_pkg
// Description : Shared decode types for the RV32I decode stage: opcode and
//               funct constants, immediate-format enum, the DecodedOp struct
//               and an opcode -> immediate-format helper.
// Revision    : 1.0  initial release
// ============================================================================
package decode_stage_pkg;

  // Immediate width carried in decoded_op_t; the stage's DATA_WIDTH must match.
  localparam int DECODE_DATA_WIDTH = 32;

  // RV32I major opcodes recognised by the decoder
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // funct7 values legal on the OP opcode
  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // ALU / branch codes reuse the funct3 encoding
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] BR_EQ   = 3'b000;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_format_e;

  typedef struct packed {
    logic [6:0]                   opcode;
    logic [4:0]                   rd;
    logic [4:0]                   rs1;
    logic [4:0]                   rs2;
    logic [2:0]                   funct3;
    logic [6:0]                   funct7;
    logic [4:0]                   shamt;
    logic [DECODE_DATA_WIDTH-1:0] imm;
    logic [2:0]                   alu_code;
    logic [2:0]                   br_code;
    logic                         is_branch;
    logic                         is_jump;
    logic                         is_load;
    logic                         is_store;
    logic                         is_alu_in_constant;
    logic                         reg_wr_enable;
    logic                         is_illegal;
    logic                         is_mul_div;
  } decoded_op_t;

  // Which immediate layout an opcode uses; unknown opcodes carry no immediate.
  function automatic imm_format_e imm_format_of(input logic [6:0] opcode);
    imm_format_e fmt;
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = IMM_I;
      OPC_STORE:                      fmt = IMM_S;
      OPC_BRANCH:                     fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:             fmt = IMM_U;
      OPC_JAL:                        fmt = IMM_J;
      default:                        fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen
// Description : Combinational RV32I immediate generator. Assembles the I/S/B/
//               U/J immediate from the instruction and sign-extends it from
//               insn[31] to DATA_WIDTH. Opcode bits are not needed here.
// Revision    : 1.0  initial release
// ============================================================================
module imm_gen
  import decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:7]           insn,
  input  imm_format_e           fmt,
  output logic [DATA_WIDTH-1:0] imm
);

  logic [31:0] imm32;

  // Assemble the 32-bit immediate for the selected format (B/J have lsb 0)
  always_comb begin
    imm32 = '0;
    case (fmt)
      IMM_I:   imm32 = {{20{insn[31]}}, insn[31:20]};
      IMM_S:   imm32 = {{20{insn[31]}}, insn[31:25], insn[11:7]};
      IMM_B:   imm32 = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
      IMM_U:   imm32 = {insn[31:12], 12'b0};
      IMM_J:   imm32 = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Widen beyond 32 bits by replicating the sign bit
  if (DATA_WIDTH > 32) begin : g_sign_ext
    assign imm = {{(DATA_WIDTH-32){imm32[31]}}, imm32};
  end else begin : g_exact
    assign imm = imm32;
  end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Registered RV32I decode stage. Decodes one instruction per
//               cycle over valid/ready and buffers the DecodedOp plus its PC in
//               a FIFO_DEPTH-entry queue so execute stalls never drop work.
//               Supports flush and flags illegal encodings.
//               Build option: DECODE_MUL_DIV_EN enables RV32M decode on OP.
// Revision    : 1.0  initial release
// ============================================================================
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DECODE_DATA_WIDTH,
  parameter int ADDR_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   insn,
  input  logic [ADDR_WIDTH-1:0]         in_pc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output decoded_op_t                   out_op,
  output logic [ADDR_WIDTH-1:0]         out_pc,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] imm_w;
  decoded_op_t           dec;
  logic                  wr_candidate;
  logic                  illegal;

  imm_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_imm_gen (
    .insn (insn[31:7]),
    .fmt  (imm_format_of(insn[6:0])),
    .imm  (imm_w)
  );

  // Field extraction, control flags and illegal detection for the incoming insn
  always_comb begin
    dec          = '0;
    wr_candidate = 1'b0;
    illegal      = 1'b0;

    dec.opcode = insn[6:0];
    dec.rd     = insn[11:7];
    dec.funct3 = insn[14:12];
    dec.rs1    = insn[19:15];
    dec.rs2    = insn[24:20];
    dec.funct7 = insn[31:25];
    dec.shamt  = insn[24:20];
    dec.imm    = imm_w;

    case (insn[6:0])
      OPC_LOAD: begin
        dec.is_load            = 1'b1;
        dec.is_alu_in_constant = 1'b1;
        dec.alu_code           = ALU_ADD;
        wr_candidate           = 1'b1;
        if (dec.funct3 == 3'b011 || dec.funct3 == 3'b110 || dec.funct3 == 3'b111)
          illegal = 1'b1;
      end
      OPC_STORE: begin
        dec.is_store           = 1'b1;
        dec.is_alu_in_constant = 1'b1;
        dec.alu_code           = ALU_ADD;
        if (dec.funct3 >= 3'b011)
          illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.is_alu_in_constant = 1'b1;
        dec.alu_code           = dec.funct3;
        wr_candidate           = 1'b1;
      end
      OPC_OP: begin
        dec.alu_code = dec.funct3;
        wr_candidate = 1'b1;
        if (dec.funct7 == FUNCT7_BASE) begin
          illegal = 1'b0;
        end else if (dec.funct7 == FUNCT7_ALT &&
                     (dec.funct3 == 3'b000 || dec.funct3 == 3'b101)) begin
          illegal = 1'b0;
`ifdef DECODE_MUL_DIV_EN
        end else if (dec.funct7 == FUNCT7_MULDIV) begin
          dec.is_mul_div = 1'b1;
`endif
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.is_alu_in_constant = 1'b1;
        dec.alu_code           = ALU_ADD;
        wr_candidate           = 1'b1;
      end
      OPC_BRANCH: begin
        dec.is_branch = 1'b1;
        dec.br_code   = dec.funct3;
        if (dec.funct3 == 3'b010 || dec.funct3 == 3'b011)
          illegal = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec.is_jump  = 1'b1;
        dec.alu_code = ALU_ADD;
        wr_candidate = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    // Compressed/invalid encodings never carry 2'b11 in the low bits
    if (insn[1:0] != 2'b11)
      illegal = 1'b1;

    // Illegal ops still travel down the pipe but must have no side effects
    dec.reg_wr_enable = wr_candidate && (dec.rd != 5'd0) && !illegal;
    dec.is_illegal    = illegal;
    if (illegal) begin
      dec.is_load    = 1'b0;
      dec.is_store   = 1'b0;
      dec.is_branch  = 1'b0;
      dec.is_jump    = 1'b0;
      dec.is_mul_div = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Output buffer
  // --------------------------------------------------------------------------
  decoded_op_t           op_mem_q [FIFO_DEPTH];
  decoded_op_t           op_mem_d [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // Ready depends only on registered state so there is no ready combinational path
  assign full      = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign occupancy = count_q;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign out_op    = empty ? '0 : op_mem_q[rd_ptr_q];
  assign out_pc    = empty ? '0 : pc_mem_q[rd_ptr_q];

  // Next-state for storage, pointers and count; flush overrides enq/deq
  always_comb begin
    op_mem_d = op_mem_q;
    pc_mem_d = pc_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        op_mem_d[wr_ptr_q] = dec;
        pc_mem_d[wr_ptr_q] = in_pc;
        wr_ptr_d           = wr_ptr_q + PTR_W'(1);
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Buffer state registers; reset clears every entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        op_mem_q[i] <= '0;
        pc_mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      op_mem_q <= op_mem_d;
      pc_mem_q <= pc_mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire
